// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the CPU port and the debug/loader port.
// Round-robin on ties, a debug burst lock with a starvation escape, and one-cycle read return.
module dmem_arbiter #(
  parameter int unsigned LOCK_MAX = 15
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_wd,
  output logic        cpu_gnt,
  output logic        cpu_stall,
  output logic        cpu_rvalid,
  output logic [15:0] cpu_rd,
  input  logic        dbg_req,
  input  logic        dbg_we,
  input  logic        dbg_lock,
  input  logic [15:0] dbg_addr,
  input  logic [15:0] dbg_wd,
  output logic        dbg_gnt,
  output logic        dbg_rvalid,
  output logic [15:0] dbg_rd,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wd,
  input  logic [15:0] mem_rd
);

  typedef enum logic {UNLOCKED, LOCKED} lock_state_t;
  typedef enum logic {GNT_CPU, GNT_DBG} last_gnt_t;

  localparam logic [3:0] LOCK_LIMIT = 4'(LOCK_MAX);

  lock_state_t state, state_next;
  last_gnt_t   last_gnt, last_gnt_next;
  logic [3:0]  starve_cnt, starve_cnt_next;
  logic        starve_fire;
  logic [15:0] addr_hold, wd_hold;
  logic        cpu_rvalid_q, dbg_rvalid_q;
  logic [15:0] cpu_rd_q, dbg_rd_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state        <= UNLOCKED;
      last_gnt     <= GNT_DBG;
      starve_cnt   <= 4'd0;
      addr_hold    <= 16'h0000;
      wd_hold      <= 16'h0000;
      cpu_rvalid_q <= 1'b0;
      dbg_rvalid_q <= 1'b0;
      cpu_rd_q     <= 16'h0000;
      dbg_rd_q     <= 16'h0000;
    end else begin
      state        <= state_next;
      last_gnt     <= last_gnt_next;
      starve_cnt   <= starve_cnt_next;
      addr_hold    <= mem_addr;
      wd_hold      <= mem_wd;
      cpu_rvalid_q <= cpu_gnt & ~cpu_we;
      dbg_rvalid_q <= dbg_gnt & ~dbg_we;
      if (cpu_gnt && !cpu_we) cpu_rd_q <= mem_rd;
      if (dbg_gnt && !dbg_we) dbg_rd_q <= mem_rd;
    end
  end

  // Starvation escape overrides the lock once the CPU has waited LOCK_MAX locked debug grants.
  always_comb begin
    cpu_gnt         = 1'b0;
    dbg_gnt         = 1'b0;
    state_next      = state;
    last_gnt_next   = last_gnt;
    starve_cnt_next = starve_cnt;
    starve_fire     = (state == LOCKED) && (starve_cnt == LOCK_LIMIT) && cpu_req;

    if (!reset) begin
      if (cpu_req && dbg_req) begin
        if (starve_fire)              cpu_gnt = 1'b1;
        else if (state == LOCKED)     dbg_gnt = 1'b1;
        else if (last_gnt == GNT_DBG) cpu_gnt = 1'b1;
        else                          dbg_gnt = 1'b1;
      end else begin
        cpu_gnt = cpu_req;
        dbg_gnt = dbg_req;
      end
    end

    if (cpu_gnt)      last_gnt_next = GNT_CPU;
    else if (dbg_gnt) last_gnt_next = GNT_DBG;

    if (dbg_gnt && dbg_lock) begin
      state_next = LOCKED;
      if (cpu_req) starve_cnt_next = starve_cnt + 4'd1;
    end else begin
      state_next      = UNLOCKED;
      starve_cnt_next = 4'd0;
    end
  end

  always_comb begin
    mem_we     = 1'b0;
    mem_addr   = addr_hold;
    mem_wd     = wd_hold;
    if (reset) begin
      mem_addr = 16'h0000;
      mem_wd   = 16'h0000;
    end else if (cpu_gnt) begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end else if (dbg_gnt) begin
      mem_we   = dbg_we;
      mem_addr = dbg_addr;
      mem_wd   = dbg_wd;
    end
  end

  // Registered read-return state is masked while reset is held so every output reads as idle.
  assign cpu_stall  = cpu_req & ~cpu_gnt & ~reset;
  assign cpu_rvalid = cpu_rvalid_q & ~reset;
  assign dbg_rvalid = dbg_rvalid_q & ~reset;
  assign cpu_rd     = reset ? 16'h0000 : cpu_rd_q;
  assign dbg_rd     = reset ? 16'h0000 : dbg_rd_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: a rule-level model queues expected per-cycle outputs
// and read returns; a monitor at negedge+2 pops and compares them against the DUT.
module tb_dmem_arbiter;
  localparam int unsigned LOCK_MAX = 15;

  logic        CLK = 1'b0;
  logic        reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = 16'h0, cpu_wd = 16'h0;
  logic        cpu_gnt, cpu_stall, cpu_rvalid;
  logic [15:0] cpu_rd;
  logic        dbg_req = 1'b0, dbg_we = 1'b0, dbg_lock = 1'b0;
  logic [15:0] dbg_addr = 16'h0, dbg_wd = 16'h0;
  logic        dbg_gnt, dbg_rvalid;
  logic [15:0] dbg_rd;
  logic        mem_we;
  logic [15:0] mem_addr, mem_wd, mem_rd;

  always #5 CLK = ~CLK;

  dmem_arbiter #(.LOCK_MAX(LOCK_MAX)) dut (
    .CLK(CLK), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wd(cpu_wd),
    .cpu_gnt(cpu_gnt), .cpu_stall(cpu_stall), .cpu_rvalid(cpu_rvalid), .cpu_rd(cpu_rd),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_lock(dbg_lock), .dbg_addr(dbg_addr), .dbg_wd(dbg_wd),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rd(dbg_rd),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wd(mem_wd), .mem_rd(mem_rd)
  );

  function automatic logic [15:0] init_word(int i);
    if (i == 4) return 16'h1234;
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // Environment memory, driven only by the DUT's memory-side outputs.
  logic [15:0] env_mem [0:65535];
  bit          env_init = 1'b0;
  assign mem_rd = env_mem[mem_addr];
  always @(posedge CLK) begin
    if (!env_init) begin
      for (int i = 0; i < 65536; i++) env_mem[i] = init_word(i);
      env_init = 1'b1;
    end
    if (mem_we === 1'b1) env_mem[mem_addr] = mem_wd;
  end

  typedef struct {
    int          cyc;
    logic        cg, dg, st, we;
    logic [15:0] addr, wd, crd, drd;
  } exp_t;
  typedef struct {
    int          cyc;
    logic [15:0] data;
  } rd_t;

  exp_t exp_q[$];
  rd_t  cpu_q[$];
  rd_t  dbg_q[$];
  int   checks = 0;
  int   errors = 0;
  int   stim_cyc = 0;
  int   mon_cyc = 0;

  // Reference model state, expressed in terms of the arbitration rules.
  logic [15:0] ref_mem [0:65535];
  bit          m_last_dbg = 1'b1;
  bit          m_locked = 1'b0;
  int          m_starve = 0;
  logic [15:0] m_addr_h = 16'h0, m_wd_h = 16'h0, m_cpu_rd = 16'h0, m_dbg_rd = 16'h0;
  bit          g_cpu = 1'b0, g_dbg = 1'b0;

  task automatic compareBit(string name, logic act, logic req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %b, expected %b", name, mon_cyc, act, req);
    end
  endtask

  task automatic compareWord(string name, logic [15:0] act, logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got %h, expected %h", name, mon_cyc, act, req);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit cr, input bit cw,
                               input logic [15:0] ca, input logic [15:0] cwd,
                               input bit dr, input bit dw, input bit dl,
                               input logic [15:0] da, input logic [15:0] dwd);
    exp_t e;
    rd_t  r;
    bit   gc, gd;
    @(negedge CLK);
    reset = rst; cpu_req = cr; cpu_we = cw; cpu_addr = ca; cpu_wd = cwd;
    dbg_req = dr; dbg_we = dw; dbg_lock = dl; dbg_addr = da; dbg_wd = dwd;
    gc = 1'b0; gd = 1'b0;
    if (!rst) begin
      if (cr && dr) begin
        if (m_locked && m_starve == int'(LOCK_MAX)) gc = 1'b1;
        else if (m_locked)                           gd = 1'b1;
        else if (m_last_dbg)                         gc = 1'b1;
        else                                         gd = 1'b1;
      end else begin
        gc = cr; gd = dr;
      end
    end
    e.cyc = stim_cyc; e.cg = gc; e.dg = gd; e.st = cr && !gc && !rst;
    e.we  = (gc && cw) || (gd && dw);
    if (rst)     begin e.addr = 16'h0; e.wd = 16'h0; end
    else if (gc) begin e.addr = ca;    e.wd = cwd;   end
    else if (gd) begin e.addr = da;    e.wd = dwd;   end
    else         begin e.addr = m_addr_h; e.wd = m_wd_h; end
    e.crd = rst ? 16'h0 : m_cpu_rd;
    e.drd = rst ? 16'h0 : m_dbg_rd;
    exp_q.push_back(e);
    if (rst) begin
      if (cpu_q.size() > 0 && cpu_q[$].cyc == stim_cyc) void'(cpu_q.pop_back());
      if (dbg_q.size() > 0 && dbg_q[$].cyc == stim_cyc) void'(dbg_q.pop_back());
      m_last_dbg = 1'b1; m_locked = 1'b0; m_starve = 0;
      m_addr_h = 16'h0; m_wd_h = 16'h0; m_cpu_rd = 16'h0; m_dbg_rd = 16'h0;
    end else begin
      if (gc || gd) begin m_last_dbg = gd; m_addr_h = e.addr; m_wd_h = e.wd; end
      if (gd && dl) begin
        m_locked = 1'b1;
        if (cr) m_starve++;
      end else begin
        m_locked = 1'b0; m_starve = 0;
      end
      if (gc && cw) ref_mem[ca] = cwd;
      if (gc && !cw) begin
        r.cyc = stim_cyc + 1; r.data = ref_mem[ca]; cpu_q.push_back(r); m_cpu_rd = r.data;
      end
      if (gd && dw) ref_mem[da] = dwd;
      if (gd && !dw) begin
        r.cyc = stim_cyc + 1; r.data = ref_mem[da]; dbg_q.push_back(r); m_dbg_rd = r.data;
      end
    end
    g_cpu = gc; g_dbg = gd;
    stim_cyc++;
  endtask

  task automatic checkOutput();
    exp_t e;
    rd_t  r;
    bit   exp_cv, exp_dv;
    e = exp_q.pop_front();
    compareBit("cpu_gnt", cpu_gnt, e.cg);
    compareBit("dbg_gnt", dbg_gnt, e.dg);
    compareBit("cpu_stall", cpu_stall, e.st);
    compareBit("mem_we", mem_we, e.we);
    compareWord("mem_addr", mem_addr, e.addr);
    compareWord("mem_wd", mem_wd, e.wd);
    compareWord("cpu_rd_hold", cpu_rd, e.crd);
    compareWord("dbg_rd_hold", dbg_rd, e.drd);
    exp_cv = cpu_q.size() > 0 && cpu_q[0].cyc == mon_cyc;
    exp_dv = dbg_q.size() > 0 && dbg_q[0].cyc == mon_cyc;
    compareBit("cpu_rvalid", cpu_rvalid, exp_cv);
    compareBit("dbg_rvalid", dbg_rvalid, exp_dv);
    if (exp_cv) begin r = cpu_q.pop_front(); compareWord("cpu_rd_data", cpu_rd, r.data); end
    if (exp_dv) begin r = dbg_q.pop_front(); compareWord("dbg_rd_data", dbg_rd, r.data); end
  endtask

  initial begin
    forever begin
      @(negedge CLK);
      #2;
      if (exp_q.size() > 0) checkOutput();
      mon_cyc++;
    end
  end

  bit          cr = 1'b0, cw = 1'b0, dr = 1'b0, dw = 1'b0, dl = 1'b0, rst = 1'b0, heavy = 1'b0;
  logic [15:0] ca = 16'h0, cwd = 16'h0, da = 16'h0, dwd = 16'h0;
  int          k = 0;

  initial begin
    for (int i = 0; i < 65536; i++) ref_mem[i] = init_word(i);

    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    // CPU-only read of 0x0004 (preloaded 0x1234)
    applyStimulus(0, 1, 0, 16'h0004, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    // Continuous contention without lock from reset: strict alternation, CPU first
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    for (int n = 0; n < 8; n++)
      applyStimulus(0, 1, 0, 16'h0004, 16'h0, 1, 0, 0, 16'h0008, 16'h0);

    // Locked debug burst of 20 writes with the CPU read held
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    k = 0;
    for (int n = 0; n < 60 && k < 20; n++) begin
      applyStimulus(0, 1, 0, 16'h0020, 16'h0, 1, 1, 1, 16'h0040 + 16'(k), 16'hD000 + 16'(k));
      if (g_dbg) k++;
    end
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    // Debug write 0xBEEF to 0x0010, then CPU read-back
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 1, 1, 0, 16'h0010, 16'hBEEF);
    applyStimulus(0, 1, 0, 16'h0010, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);

    // Reset in the middle of a locked burst with a CPU read waiting
    applyStimulus(1, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    for (int n = 0; n < 5; n++)
      applyStimulus(0, 1, 0, 16'h0010, 16'h0, 1, 1, 1, 16'h0050, 16'hA5A5);
    applyStimulus(1, 1, 0, 16'h0010, 16'h0, 1, 1, 1, 16'h0050, 16'hA5A5);
    for (int n = 0; n < 4; n++)
      applyStimulus(0, 1, 0, 16'h0010, 16'h0, 1, 1, 1, 16'h0050, 16'hA5A5);

    // Randomized traffic; alternate blocks bias toward long debug bursts
    for (int n = 0; n < 3000; n++) begin
      heavy = ((n / 250) % 2) == 1;
      if (!cr || g_cpu || rst) begin
        cr  = ($urandom_range(0, 3) != 0);
        cw  = 1'($urandom_range(0, 1));
        ca  = 16'($urandom_range(0, 31));
        cwd = 16'($urandom);
      end
      if (!dr || g_dbg || rst) begin
        dr  = heavy ? ($urandom_range(0, 15) != 0) : ($urandom_range(0, 1) == 1);
        dw  = 1'($urandom_range(0, 1));
        da  = 16'($urandom_range(0, 31));
        dwd = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) dl = !dl;
      rst = ($urandom_range(0, 249) == 0);
      applyStimulus(rst, cr, cw, ca, cwd, dr, dw, dl, da, dwd);
    end

    for (int n = 0; n < 3; n++)
      applyStimulus(0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 16'h0, 16'h0);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter LOCK_MAX, default 15: maximum consecutive debug-port grants under lock while the CPU port is waiting.
REQ-002 CLK  input  1  system clock; all state updates on posedge CLK.
REQ-003 reset  input  1  synchronous, active-high reset, sampled on posedge CLK.
REQ-004 cpu_req  input  1  CPU port requests a data-memory access this cycle.
REQ-005 cpu_we  input  1  CPU access is a write when 1, a read when 0.
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wd  input  16  CPU write data.
REQ-008 cpu_gnt  output  1  CPU access issued to memory this cycle.
REQ-009 cpu_stall  output  1  CPU must hold PC and its request; equals cpu_req AND NOT cpu_gnt.
REQ-010 cpu_rvalid  output  1  cpu_rd holds read data for the CPU read granted in the previous cycle.
REQ-011 cpu_rd  output  16  CPU read data.
REQ-012 dbg_req, dbg_we, dbg_lock  input  1 each  debug/loader request, write flag, burst lock.
REQ-013 dbg_addr, dbg_wd  input  16 each  debug address and write data.
REQ-014 dbg_gnt, dbg_rvalid  output  1 each  debug grant; debug read-data valid.
REQ-015 dbg_rd  output  16  debug read data.
REQ-016 mem_we  output  1  write enable to data memory.
REQ-017 mem_addr, mem_wd  output  16 each  address and write data to data memory.
REQ-018 mem_rd  input  16  data-memory read data, combinational from mem_addr.

Function
REQ-019 At most one of cpu_gnt, dbg_gnt SHALL be 1 in any cycle; grants are combinational from current requests and registered state.
REQ-020 Single requester: that requester SHALL be granted the same cycle.
REQ-021 Both requesting, no active lock: grant SHALL go to the port not granted most recently (round-robin pointer last_gnt; after reset the CPU wins the first tie).
REQ-022 last_gnt SHALL update on every cycle with a grant; it SHALL hold when no grant is issued.
REQ-023 Lock state LOCKED SHALL be entered when dbg_gnt=1 and dbg_lock=1; while LOCKED and dbg_req=1, debug SHALL win over a CPU request.
REQ-024 LOCKED SHALL be left when dbg_req=0, dbg_lock=0, or the starvation limit fires; the state is then UNLOCKED.
REQ-025 Starvation counter (4 bits) SHALL increment each cycle LOCKED, cpu_req=1 and dbg_gnt=1; SHALL clear when cpu_gnt=1 or on leaving LOCKED.
REQ-026 When the counter equals LOCK_MAX and cpu_req=1, the next cycle SHALL grant the CPU regardless of lock, clear the counter, and return to UNLOCKED.
REQ-027 mem_addr, mem_wd SHALL mux from the granted port; mem_we SHALL equal the granted port's we; with no grant mem_we SHALL be 0 and mem_addr/mem_wd SHALL hold their previous values.
REQ-028 Read latency one cycle: for a granted read, mem_rd SHALL be registered into the granted port's rd register; its rvalid SHALL pulse 1 the following cycle.
REQ-029 Granted writes SHALL NOT assert rvalid; rd registers SHALL hold their value when not loaded.
REQ-030 Grants in consecutive cycles to alternating ports SHALL each produce their own rvalid with no loss.
REQ-031 Requests are level-held: an ungranted requester SHALL keep req and payload stable; the arbiter need not latch payload.

Reset
REQ-032 While reset=1: cpu_gnt, dbg_gnt, mem_we, cpu_rvalid, dbg_rvalid, cpu_stall SHALL be 0; cpu_rd, dbg_rd, mem_addr, mem_wd SHALL be 0x0000; last_gnt = debug (CPU wins first tie), state UNLOCKED, counter 0.
REQ-033 Reset asserted mid-lock or with a read pending SHALL drop the lock and suppress the pending rvalid in the next cycle.

Verification
REQ-034 CPU-only read addr 0x0004, memory holds 0x1234 -> cpu_gnt same cycle, cpu_rvalid=1 and cpu_rd=0x1234 next cycle, cpu_stall=0 throughout.
REQ-035 Both request continuously, no lock, from reset -> grants CPU, dbg, CPU, dbg...; cpu_stall=1 exactly on dbg-grant cycles.
REQ-036 dbg_lock=1 burst of 20 writes with cpu_req held -> 15 consecutive dbg grants, then 1 CPU grant, then lock re-enters on next dbg grant.
REQ-037 Debug write 0xBEEF to 0x0010 then CPU read 0x0010 next cycle -> cpu_rd=0xBEEF, dbg_rvalid never 1.
REQ-038 reset pulsed during LOCKED burst with CPU read granted in the same cycle -> all outputs 0 next cycle, no rvalid, CPU wins first post-reset tie.
